skew_collector_9: RTL and testbench

Downstream neighbour of the 9-lane input skew stage: sits at the output edge of the 9-column systolic array and consumes its diagonally skewed results, where lane i of a wavefront arrives i cycles after lane 0. It de-skews the lanes back into aligned 9-word rows, buffers them in a small FIFO, and presents them to the writeback logic over a valid/ready handshake. It counts completed rows and flags dropped rows.

---
 rtl/systolic_pkg.sv | 6 +
 rtl/row_fifo.sv | 39 +++
 rtl/skew_collector_9.sv | 78 +++++++
 tb/tb_skew_collector_9.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: lane geometry shared by the input skew stage and the output skew collector
package systolic_pkg;
    localparam int LANES    = 9;
    localparam int SKEW_MAX = LANES - 1;
    localparam int INT_BITS = 20;
endpackage

// File: rtl/row_fifo.sv
// row_fifo: synchronous FIFO of aligned rows with MSB-extended wrap pointers
module row_fifo #(
    parameter int width = 180,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [width-1:0] dout
);
    localparam int AW = $clog2(depth);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [width-1:0] mem [depth];

    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    // write at the tail, advance the head on pop; callers gate push/pop against full/empty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            for (int k = 0; k < depth; k++) mem[k] <= '0;
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= din;
                wptr <= wptr + (AW+1)'(1);
            end
            if (pop) rptr <= rptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/skew_collector_9.sv
// skew_collector_9: de-skews 9 diagonally skewed lanes into aligned rows and queues them for writeback
module skew_collector_9 import systolic_pkg::*; #(
    parameter int int_bits   = INT_BITS,
    parameter int fifo_depth = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic [LANES-1:0][int_bits-1:0]    in,
    input  logic                              out_ready,
    output logic                              out_valid,
    output logic [LANES-1:0][int_bits-1:0]    out,
    output logic [15:0]                       row_count,
    output logic                              overflow
);
    logic [SKEW_MAX:1]                 vld;
    logic [LANES-1:0][int_bits-1:0]    row;
    logic                              row_valid;
    logic                              full;
    logic                              empty;
    logic                              push;
    logic                              pop;

    // vld[k] high means a wavefront started k cycles ago
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) vld <= '0;
        else vld <= {vld[SKEW_MAX-1:1], in_valid};
    end

    assign row_valid = vld[SKEW_MAX];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int D = SKEW_MAX - i;
        if (D == 0) begin : g_pass
            assign row[i] = in[i];
        end else begin : g_dly
            logic [D-1:0][int_bits-1:0] sr;
            // delay lane i by SKEW_MAX-i cycles so every lane lands with the last one
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) sr <= '0;
                else begin
                    sr[0] <= in[i];
                    for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
                end
            end
            assign row[i] = sr[D-1];
        end
    end

    assign pop       = out_valid && out_ready;
    assign push      = row_valid && (!full || pop);
    assign out_valid = !empty;

    row_fifo #(
        .width(LANES*int_bits),
        .depth(fifo_depth)
    ) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din(row),
        .full(full),
        .empty(empty),
        .dout(out)
    );

    // count accepted rows and latch a drop when a row meets a full FIFO with no pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) row_count <= row_count + 16'd1;
            if (row_valid && !push) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_skew_collector_9.sv
// tb_skew_collector_9: directed table and sequence checks for the skew collector
module tb_skew_collector_9;
    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic [8:0][19:0] din = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [8:0][19:0] dout;
    logic [15:0]      row_count;
    logic             overflow;

    int total = 0;
    int bad = 0;
    int gc = 0;
    logic        hist_v [16];
    logic [19:0] hist_b [16];

    typedef struct {
        logic        v;
        logic [19:0] b;
        logic        r;
        logic        ev;
        logic [19:0] eb;
        logic [15:0] ec;
        logic        ef;
    } vec_t;

    vec_t tbl [12];

    skew_collector_9 dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in(din),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out(dout),
        .row_count(row_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step(input logic v, input logic [19:0] b, input logic r);
        hist_v[gc % 16] = v;
        hist_b[gc % 16] = b;
        in_valid = v;
        out_ready = r;
        for (int i = 0; i < 9; i++) begin
            int s = gc - i;
            din[i] = (s >= 0 && hist_v[s % 16]) ? hist_b[s % 16] + 20'(i) : 20'hABCDE ^ 20'(gc * 7 + i);
        end
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        gc++;
    endtask

    task automatic chk(input string nm, input logic ev, input logic [19:0] eb, input logic [15:0] ec, input logic ef);
        logic ok;
        total++;
        if (out_valid !== ev) begin
            bad++;
            $display("FAIL %s c=%0d out_valid got %0b want %0b", nm, gc, out_valid, ev);
        end
        if (ev) begin
            ok = 1'b1;
            for (int i = 0; i < 9; i++) if (dout[i] !== eb + 20'(i)) ok = 1'b0;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL %s c=%0d out lane0 got %0d lane8 got %0d want %0d..%0d", nm, gc, dout[0], dout[8], eb, eb + 20'd8);
            end
        end
        total++;
        if (row_count !== ec || overflow !== ef) begin
            bad++;
            $display("FAIL %s c=%0d row_count/overflow got %0d/%0b want %0d/%0b", nm, gc, row_count, overflow, ec, ef);
        end
    endtask

    task automatic chk_zero(input string nm);
        total++;
        if (out_valid !== 1'b0 || dout !== '0 || row_count !== 16'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL %s valid=%0b out0=%0d count=%0d ovf=%0b want all 0", nm, out_valid, dout[0], row_count, overflow);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        din = '0;
        #2;
        chk_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        gc = 0;
        for (int k = 0; k < 16; k++) begin
            hist_v[k] = 1'b0;
            hist_b[k] = '0;
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 20'd100, 1'b1, 1'b0, 20'd0,   16'd0, 1'b0};
        tbl[1]  = '{1'b0, 20'd0,   1'b1, 1'b0, 20'd0,   16'd0, 1'b0};
        tbl[2]  = '{1'b0, 20'd0,   1'b1, 1'b0, 20'd0,   16'd0, 1'b0};
        tbl[3]  = '{1'b0, 20'd0,   1'b1, 1'b0, 20'd0,   16'd0, 1'b0};
        tbl[4]  = '{1'b0, 20'd0,   1'b1, 1'b0, 20'd0,   16'd0, 1'b0};
        tbl[5]  = '{1'b0, 20'd0,   1'b1, 1'b0, 20'd0,   16'd0, 1'b0};
        tbl[6]  = '{1'b0, 20'd0,   1'b1, 1'b0, 20'd0,   16'd0, 1'b0};
        tbl[7]  = '{1'b0, 20'd0,   1'b1, 1'b0, 20'd0,   16'd0, 1'b0};
        tbl[8]  = '{1'b0, 20'd0,   1'b1, 1'b0, 20'd0,   16'd0, 1'b0};
        tbl[9]  = '{1'b0, 20'd0,   1'b1, 1'b1, 20'd100, 16'd1, 1'b0};
        tbl[10] = '{1'b0, 20'd0,   1'b1, 1'b0, 20'd0,   16'd1, 1'b0};
        tbl[11] = '{1'b0, 20'd0,   1'b1, 1'b0, 20'd0,   16'd1, 1'b0};

        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(tbl[c].v, tbl[c].b, tbl[c].r);
            chk("single", tbl[c].ev, tbl[c].eb, tbl[c].ec, tbl[c].ef);
            adv();
        end

        do_reset();
        for (int c = 0; c < 28; c++) begin
            step(c < 16, 20'(16 * c), 1'b1);
            chk("stream", c >= 9 && c <= 24, 20'(16 * (c - 9)), 16'(c < 9 ? 0 : (c - 8 > 16 ? 16 : c - 8)), 1'b0);
            adv();
        end

        do_reset();
        for (int c = 0; c < 19; c++) begin
            step(c < 5, 20'(16 * c), c >= 14);
            if (c < 9) chk("fill", 1'b0, 20'd0, 16'd0, 1'b0);
            else if (c <= 13) chk("fill", 1'b1, 20'd0, 16'(c - 8 > 4 ? 4 : c - 8), c >= 13);
            else if (c <= 17) chk("drain", 1'b1, 20'(16 * (c - 14)), 16'd4, 1'b1);
            else chk("drain_end", 1'b0, 20'd0, 16'd4, 1'b1);
            adv();
        end

        do_reset();
        for (int c = 0; c < 19; c++) begin
            step(c < 5, 20'(16 * c), c == 12 || c >= 14);
            if (c < 9) chk("fullpop", 1'b0, 20'd0, 16'd0, 1'b0);
            else if (c <= 12) chk("fullpop", 1'b1, 20'd0, 16'(c - 8), 1'b0);
            else if (c == 13) chk("fullpop", 1'b1, 20'd16, 16'd5, 1'b0);
            else if (c <= 17) chk("fullpop_drain", 1'b1, 20'(16 * (c - 13)), 16'd5, 1'b0);
            else chk("fullpop_end", 1'b0, 20'd0, 16'd5, 1'b0);
            adv();
        end

        do_reset();
        for (int c = 0; c < 11; c++) begin
            step(c == 0 || c == 1 || c == 6, 20'(500 + 16 * c), 1'b0);
            if (c == 10) chk("pre_reset", 1'b1, 20'd500, 16'd2, 1'b0);
            adv();
        end
        step(1'b0, 20'd0, 1'b0);
        reset = 1'b0;
        #2;
        chk_zero("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        gc = 0;
        for (int k = 0; k < 16; k++) hist_v[k] = 1'b0;
        for (int c = 0; c < 14; c++) begin
            step(1'b0, 20'd0, 1'b1);
            chk("post_reset", 1'b0, 20'd0, 16'd0, 1'b0);
            adv();
        end

        do_reset();
        for (int c = 0; c < 65537 + 10; c++) begin
            step(c < 65537, 20'(c), 1'b1);
            if (c == 65544) chk("wrap0", 1'b1, 20'd65535, 16'd0, 1'b0);
            adv();
        end
        chk("wrap1", 1'b0, 20'd0, 16'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
